buffer_fifo: RTL

//   Parametrised successor to the single-stage data buffer: a synchronous FIFO of Depth

---
 rtl/buffer_pkg.sv | 27 ++
 rtl/buffer_fifo_mem.sv | 59 +++++
 rtl/buffer_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// ----------------------------------------------------------------------------
// buffer_pkg
//   Shared helpers for the buffer_fifo block.
//   - addr_w(depth) : pointer width for a FIFO of 'depth' entries
//   - lvl_w(depth)  : occupancy counter width (holds 0..depth inclusive)
//   - ptr_inc(p, d) : increment a pointer, wrapping d-1 -> 0
//   Used by buffer_fifo (optional feature macro: BUFFER_FIFO_ERR_EN) and
//   buffer_fifo_mem.
// ----------------------------------------------------------------------------
package buffer_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit compare-and-wrap so the helper also works for depths that are
  // not a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage : buffer_pkg

// File: rtl/buffer_fifo_mem.sv
// ----------------------------------------------------------------------------
// buffer_fifo_mem
//   Depth x Width register file used as FIFO storage.
//   Asynchronous active-low clear, one synchronous write port, one
//   combinational read port (first-word-fall-through needs the head entry
//   visible in the same cycle the read pointer points at it).
// Ports
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low clear of all entries
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, combinational from storage
// ----------------------------------------------------------------------------
module buffer_fifo_mem
  import buffer_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [addr_w(Depth)-1:0]   waddr_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic [addr_w(Depth)-1:0]   raddr_i,
  output logic [Width-1:0]           rdata_o
);

  localparam int AddrW = addr_w(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
      if (we_i && (waddr_i == AddrW'(i))) begin
        mem_d[i] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : buffer_fifo_mem

// File: rtl/buffer_fifo.sv
// ----------------------------------------------------------------------------
// buffer_fifo
//   Synchronous first-word-fall-through FIFO, Depth entries x Width bits,
//   valid/ready handshake on both sides. Absorbs backpressure between a
//   producer and a consumer in the same clock domain.
// Parameters
//   Width         data width (>= 1)
//   Depth         entries (power of two, >= 2)
//   AlmostFullTh  afull_o asserts when level_o >= AlmostFullTh
// Ports
//   clk_i     in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   d_i       in   write data
//   wvalid_i  in   write request
//   wready_o  out  space available (not full)
//   q_o       out  head data, valid while rvalid_o = 1
//   rvalid_o  out  FIFO non-empty
//   rready_i  in   consumer accepts head
//   level_o   out  occupancy 0..Depth
//   afull_o   out  level_o >= AlmostFullTh
//   ovf_o     out  sticky overflow   (only with BUFFER_FIFO_ERR_EN)
//   udf_o     out  sticky underflow  (only with BUFFER_FIFO_ERR_EN)
// Optional feature macro: BUFFER_FIFO_ERR_EN
// ----------------------------------------------------------------------------
module buffer_fifo
  import buffer_pkg::*;
#(
  parameter int Width        = 8,
  parameter int Depth        = 4,
  parameter int AlmostFullTh = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [Width-1:0]          d_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  output logic [Width-1:0]          q_o,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  output logic [lvl_w(Depth)-1:0]   level_o,
  output logic                      afull_o
`ifdef BUFFER_FIFO_ERR_EN
  ,
  output logic                      ovf_o,
  output logic                      udf_o
`endif
);

  localparam int AddrW = addr_w(Depth);
  localparam int LvlW  = lvl_w(Depth);

  localparam logic [LvlW-1:0] LvlFull  = LvlW'(Depth);
  localparam logic [LvlW-1:0] LvlAfull = LvlW'(AlmostFullTh);

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q,  level_d;
  // Last value handed to the consumer; shown on q_o while empty so the
  // output does not wander to stale storage after the final pop.
  logic [Width-1:0] hold_q,   hold_d;

  logic             push;
  logic             pop;
  logic [Width-1:0] rd_data;

  // Handshake status is decoded purely from registered occupancy.
  assign wready_o = (level_q != LvlFull);
  assign rvalid_o = (level_q != '0);
  assign afull_o  = (level_q >= LvlAfull);
  assign level_o  = level_q;

  assign push = wvalid_i & wready_o;
  assign pop  = rvalid_o & rready_i;

  buffer_fifo_mem #(
    .Width (Width),
    .Depth (Depth)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (d_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // A push into an empty FIFO lands in storage at the edge, so it reaches
  // q_o only together with rvalid_o in the following cycle.
  assign q_o = rvalid_o ? rd_data : hold_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;

    if (push) begin
      wr_ptr_d = AddrW'(ptr_inc(32'(wr_ptr_q), Depth));
    end
    if (pop) begin
      rd_ptr_d = AddrW'(ptr_inc(32'(rd_ptr_q), Depth));
      hold_d   = rd_data;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

`ifdef BUFFER_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky: once an illegal request is seen the flag stays up until reset.
  always_comb begin
    ovf_d = ovf_q | (wvalid_i & ~wready_o);
    udf_d = udf_q | (rready_i & ~rvalid_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule : buffer_fifo
